ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS EX stage; runs beside the combinational ALU.
- Owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO, decoded from the same 6-bit funct field the ALU uses.
- Stalls the pipeline through o_busy while an iterative operation is in flight.

Parameters:
- NB_DATA, 32, operand and HI/LO width; must be ≥ 4 and even.
- NB_FUNCT, 6, funct/control field width.
- NB_COUNT, $clog2(NB_DATA)+1, iteration counter width.

Ports:
- i_clk  in  1  clock; all state on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  issue strobe; sampled together with i_funct, i_a and i_b.
- i_funct  in  NB_FUNCT  operation code.
- i_a  in  NB_DATA  rs operand; multiplicand, dividend, or MTHI/MTLO data.
- i_b  in  NB_DATA  rt operand; multiplier or divisor.
- o_result  out  NB_DATA  HI for MFHI, LO for MFLO, otherwise 0; combinational from i_funct.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_busy  out  1  operation in flight; pipeline stall request.
- o_done  out  1  one-cycle pulse in the cycle HI/LO take the new result.

Behaviour:
- Reset: state IDLE; HI, LO, counter and internal accumulators all 0; o_busy=0, o_done=0. Reset is synchronous, active-high, and overrides all other activity.
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - Any other code: no effect, o_result=0.
- MTHI/MTLO:
  - Accepted only in IDLE with i_start=1.
  - HI or LO takes i_a on the same edge.
  - No busy, no o_done.
- MFHI/MFLO:
  - o_result reflects the register value of the current cycle.
  - MF issued while o_busy=1 returns the old value; the pipeline must honour o_busy.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE:
    - i_start with MULT/MULTU/DIV/DIVU latches operand magnitudes (signed ops) or raw operands (unsigned), latches result-sign flags, and sets counter=NB_DATA.
    - Goes to CALC; o_busy=1 from the next cycle.
  - CALC, multiply: radix-2 shift-add, one bit per cycle.
  - CALC, divide: restoring shift-subtract, one quotient bit per cycle.
  - CALC exit: counter decrements each cycle; at 0 go to FIX.
  - FIX:
    - Two's-complement negation of the product when the operand signs differ.
    - Quotient negated when the signs differ.
    - Remainder takes the sign of the dividend.
  - DONE:
    - HI/LO written: product high/low, or remainder/quotient.
    - o_done=1; o_busy=0 in this cycle; return to IDLE.
- Latency: i_start at cycle 0 -> o_done and new HI/LO at cycle NB_DATA+2; o_busy high for cycles 1..NB_DATA+1.
- Divide by zero (i_b==0, DIV or DIVU):
  - IDLE -> DONE directly.
  - LO = all ones, HI = i_a.
  - o_done at cycle 1; o_busy stays 0 throughout.
- Signed overflow: DIV of most-negative by -1 gives LO = most-negative, HI = 0; no trap.
- i_start while o_busy=1 or in DONE: ignored, including MT*; no queueing.
- Arithmetic: full 2*NB_DATA product with no truncation; wrap-around only in the documented overflow case.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply CALC exits to FIX as soon as the remaining multiplier bits are all zero, with the product pre-shifted to its final alignment.
  - Latency becomes (index of highest set multiplier-magnitude bit + 1) + 2 cycles.
  - A zero multiplier gives 2 cycles.
  - Divide timing is unchanged.
- Undefined: fixed NB_DATA+2 latency for every multiply and divide.
- HI/LO values are identical in both builds.

Decomposition:
- Package muldiv_pkg:
  - Funct localparams (FUNCT_MFHI … FUNCT_DIVU).
  - State encoding typedef (ST_IDLE, ST_CALC, ST_FIX, ST_DONE).
  - Helper function for two's-complement magnitude.
- Sub-module muldiv_shift_core:
  - Shared 2*NB_DATA accumulator and shift datapath, performing one add-or-subtract step per enable.
  - ex_muldiv_unit keeps the FSM, sign handling, HI/LO registers and the MF mux.

Test Plan (NB_DATA=32):
1. MULT A=0xFFFFFFFF, B=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; o_done exactly at cycle 34; o_busy high for cycles 1..33.
2. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. Then MFHI -> o_result=0x00000001, and MFLO -> o_result=0xFFFFFFFE.
3. DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
4. DIVU A=0x00000007, B=0 -> LO=0xFFFFFFFF, HI=0x00000007; o_done at cycle 1; o_busy never asserted.
5. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
6. MTHI 0x12345678 in IDLE -> HI=0x12345678 on the next edge. Start MULTU, issue MTLO 0xAAAAAAAA at cycle 5 -> ignored. Assert i_rst at cycle 10 -> next cycle o_busy=0, HI=LO=0, and no o_done pulse ever follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - funct codes decoded by ex_muldiv_unit (same 6-bit field as the ALU)
//   - FSM state encoding
//   - conditional two's-complement helper used for operand magnitudes and
//     result sign fix-up
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    // Helper width: wide enough for a 2*NB_DATA product with NB_DATA up to 64.
    // Callers zero-extend into it and cast the result back to their width.
    localparam int unsigned MAX_NB = 128;

    // Negate when asked, otherwise pass through (magnitude / sign restore).
    function automatic logic [MAX_NB-1:0] twos_mag(input logic [MAX_NB-1:0] value,
                                                   input logic              negate);
        return negate ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// muldiv_shift_core: shared 2*NB_DATA accumulator for iterative multiply and divide.
//   Multiply (radix-2 shift-add): acc = {partial, multiplier}; add operand to the
//   high half when acc[0] is set, then shift right one bit.
//   Divide (restoring): acc = {remainder, dividend/quotient}; shift left one bit,
//   trial-subtract operand from the high part, keep it and shift in 1 if it fits.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load acc from i_load_val (wins over i_step)
//   i_load_val       value to load
//   i_step           perform one iteration
//   i_is_div         1: divide step, 0: multiply step
//   i_operand        multiplicand or divisor
//   o_acc            current accumulator
//   o_acc_step       accumulator value after one iteration (combinational)
module muldiv_shift_core #(
    parameter int unsigned NB_DATA = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [2*NB_DATA-1:0]   i_load_val,
    input  logic                   i_step,
    input  logic                   i_is_div,
    input  logic [NB_DATA-1:0]     i_operand,
    output logic [2*NB_DATA-1:0]   o_acc,
    output logic [2*NB_DATA-1:0]   o_acc_step
);

    logic [2*NB_DATA-1:0] acc_q;
    logic [NB_DATA:0]     sum;
    logic [NB_DATA:0]     shifted_hi;
    logic [NB_DATA:0]     diff;

    always_comb begin
        sum        = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, i_operand};
        shifted_hi = acc_q[2*NB_DATA-1:NB_DATA-1];
        diff       = shifted_hi - {1'b0, i_operand};
        o_acc_step = acc_q;
        if (i_is_div) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (diff[NB_DATA]) begin
                o_acc_step = {shifted_hi[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
            end else begin
                o_acc_step = {diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
            end
        end else if (acc_q[0]) begin
            o_acc_step = {sum, acc_q[NB_DATA-1:1]};
        end else begin
            o_acc_step = {1'b0, acc_q[2*NB_DATA-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
        end else if (i_load) begin
            acc_q <= i_load_val;
        end else if (i_step) begin
            acc_q <= o_acc_step;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle MIPS multiply/divide unit owning HI/LO.
//   Executes MULT/MULTU/DIV/DIVU iteratively (IDLE -> CALC -> FIX -> DONE),
//   MTHI/MTLO in one edge, MFHI/MFLO as a combinational read on o_result.
//   HI/LO are written on the FIX->DONE edge so they show the new result in the
//   same cycle as o_done.
// Build option: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the
//   remaining multiplier bits are zero (divide timing unchanged).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        issue strobe, sampled with i_funct/i_a/i_b
//   i_funct        operation code
//   i_a, i_b       rs / rt operands
//   o_result       HI for MFHI, LO for MFLO, else 0 (combinational on i_funct)
//   o_hi, o_lo     HI/LO registers
//   o_busy         operation in flight (pipeline stall)
//   o_done         one-cycle pulse when HI/LO take a new result
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_FUNCT = 6,
    parameter int unsigned NB_COUNT = $clog2(NB_DATA) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_a,
    input  logic [NB_DATA-1:0]  i_b,
    output logic [NB_DATA-1:0]  o_result,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo,
    output logic                o_busy,
    output logic                o_done
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int unsigned NB_ACC = 2 * NB_DATA;

    state_e              state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_DATA-1:0]  opnd_q, opnd_d;
    logic [NB_DATA-1:0]  hi_q, hi_d;
    logic [NB_DATA-1:0]  lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;  // negate product / quotient
    logic                neg_hi_q, neg_hi_d;  // negate remainder

    logic                signed_op;
    logic [NB_DATA-1:0]  a_mag, b_mag;
    logic                core_load, core_step;
    logic [NB_ACC-1:0]   core_load_val, acc, acc_step;
    logic [NB_COUNT-1:0] remaining;
    logic [NB_ACC-1:0]   rem_mask;
    logic [NB_ACC-1:0]   prod_fix;
    logic [NB_DATA-1:0]  quot_fix, rem_fix;

    // Odd funct codes in the MULT..DIVU block are the unsigned variants.
    assign signed_op = ~i_funct[0];
    assign a_mag = NB_DATA'(twos_mag(MAX_NB'(i_a), signed_op & i_a[NB_DATA-1]));
    assign b_mag = NB_DATA'(twos_mag(MAX_NB'(i_b), signed_op & i_b[NB_DATA-1]));

    // Multiplier bits not yet consumed sit in acc_step[remaining-1:0].
    assign remaining = count_q - NB_COUNT'(1);
    assign rem_mask  = ~({NB_ACC{1'b1}} << remaining);

    assign prod_fix = NB_ACC'(twos_mag(MAX_NB'(acc), neg_lo_q));
    assign quot_fix = NB_DATA'(twos_mag(MAX_NB'(acc[NB_DATA-1:0]), neg_lo_q));
    assign rem_fix  = NB_DATA'(twos_mag(MAX_NB'(acc[NB_ACC-1:NB_DATA]), neg_hi_q));

    muldiv_shift_core #(
        .NB_DATA (NB_DATA)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (core_load),
        .i_load_val (core_load_val),
        .i_step     (core_step),
        .i_is_div   (is_div_q),
        .i_operand  (opnd_q),
        .o_acc      (acc),
        .o_acc_step (acc_step)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        opnd_d        = opnd_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        is_div_d      = is_div_q;
        neg_lo_d      = neg_lo_q;
        neg_hi_d      = neg_hi_q;
        core_load     = 1'b0;
        core_load_val = '0;
        core_step     = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    case (i_funct)
                        FUNCT_MTHI: hi_d = i_a;
                        FUNCT_MTLO: lo_d = i_a;
                        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                            is_div_d = i_funct[1];
                            neg_lo_d = signed_op & (i_a[NB_DATA-1] ^ i_b[NB_DATA-1]);
                            neg_hi_d = signed_op & i_funct[1] & i_a[NB_DATA-1];
                            if (i_funct[1] && (i_b == '0)) begin
                                hi_d    = i_a;
                                lo_d    = '1;
                                state_d = ST_DONE;
                            end else begin
                                core_load     = 1'b1;
                                core_load_val = i_funct[1] ? {{NB_DATA{1'b0}}, a_mag}
                                                           : {{NB_DATA{1'b0}}, b_mag};
                                opnd_d        = i_funct[1] ? b_mag : a_mag;
                                count_d       = NB_COUNT'(NB_DATA);
                                state_d       = ST_CALC;
                                // Zero multiplier: product is already the loaded 0.
                                if (EARLY_OUT && !i_funct[1] && (b_mag == '0)) begin
                                    state_d = ST_FIX;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                o_busy    = 1'b1;
                core_step = 1'b1;
                count_d   = remaining;
                if (count_q == NB_COUNT'(1)) begin
                    state_d = ST_FIX;
                end
                // Early exit shifts the partial product straight to final alignment.
                if (EARLY_OUT && !is_div_q && ((acc_step & rem_mask) == '0)) begin
                    core_load     = 1'b1;
                    core_load_val = acc_step >> remaining;
                    state_d       = ST_FIX;
                end
            end
            ST_FIX: begin
                o_busy = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[NB_ACC-1:NB_DATA];
                    lo_d = prod_fix[NB_DATA-1:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    always_comb begin
        case (i_funct)
            FUNCT_MFHI: o_result = hi_q;
            FUNCT_MFLO: o_result = lo_q;
            default:    o_result = '0;
        endcase
    end

    assign o_hi = hi_q;
    assign o_lo = lo_q;

endmodule
